ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- Parametrised EX→MEM pipeline register for the MIPS32 core; successor to the basic EX/MEM latch.
- Adds stall and flush control, bubble insertion, and a valid flag.
- Forwards memory-access fields (aluop, address, store data).
- Holds the multi-cycle accumulator state (hilo_temp, cnt) that EX needs for MADD/MSUB across stall cycles.
- Sits between ex and mem; stall/flush come from ctrl.

Parameters:
- DATA_W, 32, width of GPR data, HI, LO, address and store data.
- REG_ADDR_W, 5, width of destination register address.
- ALUOP_W, 8, width of ALU/memory opcode passed to MEM.
- CNT_W, 2, width of the multi-cycle step counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- stall_ex  in  1  EX stage stalled this cycle.
- stall_mem  in  1  MEM stage stalled this cycle.
- flush  in  1  exception flush; kills the stage contents.
- ex_wd  in  REG_ADDR_W  destination register.
- ex_wreg  in  1  GPR write enable.
- ex_wdata  in  DATA_W  GPR write data.
- ex_hi  in  DATA_W  HI write value.
- ex_lo  in  DATA_W  LO write value.
- ex_whilo  in  1  HI/LO write enable.
- ex_aluop  in  ALUOP_W  opcode for load/store decode in MEM.
- ex_mem_addr  in  DATA_W  effective memory address.
- ex_reg2  in  DATA_W  store data.
- hilo_temp_i  in  2*DATA_W  partial MADD/MSUB product from EX.
- cnt_i  in  CNT_W  EX multi-cycle step count.
- mem_wd  out  REG_ADDR_W
- mem_wreg  out  1
- mem_wdata  out  DATA_W
- mem_hi  out  DATA_W
- mem_lo  out  DATA_W
- mem_whilo  out  1
- mem_aluop  out  ALUOP_W
- mem_mem_addr  out  DATA_W
- mem_reg2  out  DATA_W
- mem_valid  out  1  stage holds a real instruction (0 = bubble).
- hilo_temp_o  out  2*DATA_W  partial product fed back to EX.
- cnt_o  out  CNT_W  step count fed back to EX.

Behaviour:
- All outputs are registered and update on posedge clk. Latency is 1 cycle, with no combinational input→output path.
- Reset (rst=0, asynchronous, takes effect immediately regardless of clk): every output is 0. This includes mem_wreg=0, mem_whilo=0, mem_valid=0, hilo_temp_o=0 and cnt_o=0. This fixes the old latch, which left HI/LO fields unreset.
- Priority at each edge, highest first:
  1. flush=1: all outputs are cleared to 0, including hilo_temp_o and cnt_o. The in-flight accumulation is abandoned.
  2. stall_ex=1 and stall_mem=0: a bubble is inserted.
     - All mem_* outputs are cleared to 0 and mem_valid=0.
     - hilo_temp_o←hilo_temp_i and cnt_o←cnt_i, so EX sees its partial result next cycle.
  3. stall_ex=0: normal advance.
     - All mem_* outputs capture the corresponding ex_* inputs and mem_valid=1.
     - hilo_temp_o←0 and cnt_o←0 (the accumulation is complete).
  4. Otherwise (stall_ex=1 and stall_mem=1): all outputs hold, including hilo_temp_o and cnt_o.
- stall_ex=0 with stall_mem=1 is illegal because ctrl never produces it. If it occurs, the block follows rule 3 (advance); the bench flags it as an assertion warning only.
- Flush during a multi-cycle MADD: the next-cycle cnt_o is 0, and the outputs stay at 0 until a new non-stalled capture.
- Widths are pass-through with no arithmetic. hilo_temp is exactly 2*DATA_W bits, and cnt wraps are EX's responsibility; this block never modifies their values.
- Reset deasserting mid-stall: the first edge after release applies the rules above to the current inputs.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs → every output reads 0, including during mid-cycle rst assertion, without waiting for an edge.
- Normal flow: stall_ex=0, ex_wd=5'h1F, ex_wreg=1, ex_wdata=32'hDEADBEEF, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2 → next edge mem_* equal the inputs and mem_valid=1, hilo_temp_o=0 and cnt_o=0.
- MADD bubble: stall_ex=1, stall_mem=0, hilo_temp_i=64'h0000_0001_0000_0002, cnt_i=1 → mem_wreg=0, mem_valid=0, hilo_temp_o=64'h0000_0001_0000_0002 and cnt_o=1. On the following cycle with stall_ex=0 → cnt_o=0 and the mem_* outputs capture.
- Full hold: load known values, then stall_ex=1 and stall_mem=1 for 4 cycles while inputs toggle → all outputs unchanged.
- Flush priority: flush=1 together with stall_ex=1, stall_mem=0 and cnt_i=1 → all outputs 0, including cnt_o=0 and hilo_temp_o=0.
- Parameter sweep: DATA_W=64 and REG_ADDR_W=6 → the normal-flow test passes with ex_wdata=64'hFFFF_0000_FFFF_0000 carried intact.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with stall, flush and bubble handling.
// Also carries the MADD/MSUB accumulator state back to EX across stalls.
module ex_mem_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_ex,
  input  logic                  stall_mem,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   hilo_temp_i,
  input  logic [CNT_W-1:0]      cnt_i,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic                  mem_valid,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [CNT_W-1:0]      cnt_o
);

  logic advance;
  logic bubble;

  // An EX stall with MEM free drains a bubble; with MEM stalled too, hold.
  assign advance = !stall_ex;
  assign bubble  = stall_ex && !stall_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= 1'b0;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      mem_valid    <= 1'b0;
      hilo_temp_o  <= '0;
      cnt_o        <= '0;
    end else if (flush) begin
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= 1'b0;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      mem_valid    <= 1'b0;
      hilo_temp_o  <= '0;
      cnt_o        <= '0;
    end else if (advance) begin
      mem_wd       <= ex_wd;
      mem_wreg     <= ex_wreg;
      mem_wdata    <= ex_wdata;
      mem_hi       <= ex_hi;
      mem_lo       <= ex_lo;
      mem_whilo    <= ex_whilo;
      mem_aluop    <= ex_aluop;
      mem_mem_addr <= ex_mem_addr;
      mem_reg2     <= ex_reg2;
      mem_valid    <= 1'b1;
      hilo_temp_o  <= '0;
      cnt_o        <= '0;
    end else if (bubble) begin
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= 1'b0;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      mem_valid    <= 1'b0;
      hilo_temp_o  <= hilo_temp_i;
      cnt_o        <= cnt_i;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed-vector bench for ex_mem_reg.
// Covers reset, advance, bubble, hold, flush and a 64-bit instance.
module tb_ex_mem_reg;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stall_ex;
  logic        stall_mem;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic        mem_valid;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  logic [5:0]   w_wd;
  logic         w_wreg;
  logic [63:0]  w_wdata;
  logic [63:0]  w_hi;
  logic [63:0]  w_lo;
  logic         w_whilo;
  logic [7:0]   w_aluop;
  logic [63:0]  w_addr;
  logic [63:0]  w_reg2;
  logic [127:0] w_hilo_i;
  logic [1:0]   w_cnt_i;
  logic [5:0]   wo_wd;
  logic         wo_wreg;
  logic [63:0]  wo_wdata;
  logic [63:0]  wo_hi;
  logic [63:0]  wo_lo;
  logic         wo_whilo;
  logic [7:0]   wo_aluop;
  logic [63:0]  wo_addr;
  logic [63:0]  wo_reg2;
  logic         wo_valid;
  logic [127:0] wo_hilo;
  logic [1:0]   wo_cnt;

  int n_chk;
  int n_pass;

  ex_mem_reg dut (
    .clk          (clk),
    .rst          (rst),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .flush        (flush),
    .ex_wd        (ex_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .ex_whilo     (ex_whilo),
    .ex_aluop     (ex_aluop),
    .ex_mem_addr  (ex_mem_addr),
    .ex_reg2      (ex_reg2),
    .hilo_temp_i  (hilo_temp_i),
    .cnt_i        (cnt_i),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .mem_whilo    (mem_whilo),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .mem_valid    (mem_valid),
    .hilo_temp_o  (hilo_temp_o),
    .cnt_o        (cnt_o)
  );

  ex_mem_reg #(.DATA_W(64), .REG_ADDR_W(6)) dut64 (
    .clk          (clk),
    .rst          (rst),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .flush        (flush),
    .ex_wd        (w_wd),
    .ex_wreg      (w_wreg),
    .ex_wdata     (w_wdata),
    .ex_hi        (w_hi),
    .ex_lo        (w_lo),
    .ex_whilo     (w_whilo),
    .ex_aluop     (w_aluop),
    .ex_mem_addr  (w_addr),
    .ex_reg2      (w_reg2),
    .hilo_temp_i  (w_hilo_i),
    .cnt_i        (w_cnt_i),
    .mem_wd       (wo_wd),
    .mem_wreg     (wo_wreg),
    .mem_wdata    (wo_wdata),
    .mem_hi       (wo_hi),
    .mem_lo       (wo_lo),
    .mem_whilo    (wo_whilo),
    .mem_aluop    (wo_aluop),
    .mem_mem_addr (wo_addr),
    .mem_reg2     (wo_reg2),
    .mem_valid    (wo_valid),
    .hilo_temp_o  (wo_hilo),
    .cnt_o        (wo_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ctrl never issues an EX advance into a stalled MEM
  always @(posedge clk) begin
    if (rst)
      assert (!(!stall_ex && stall_mem))
        else $warning("illegal stall combination");
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    ex_wd       = v.wd;
    ex_wreg     = v.wreg;
    ex_wdata    = v.wdata;
    ex_hi       = v.hi;
    ex_lo       = v.lo;
    ex_whilo    = v.whilo;
    ex_aluop    = v.aluop;
    ex_mem_addr = v.addr;
    ex_reg2     = v.reg2;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.wd    = 5'($urandom);
    v.wreg  = 1'($urandom);
    v.wdata = $urandom;
    v.hi    = $urandom;
    v.lo    = $urandom;
    v.whilo = 1'($urandom);
    v.aluop = 8'($urandom);
    v.addr  = $urandom;
    v.reg2  = $urandom;
    return v;
  endfunction

  task automatic exp_mem(input string t, input vec_t v, input logic valid);
    chk({t, ".wd"},    128'(mem_wd),       128'(v.wd));
    chk({t, ".wreg"},  128'(mem_wreg),     128'(v.wreg));
    chk({t, ".wdata"}, 128'(mem_wdata),    128'(v.wdata));
    chk({t, ".hi"},    128'(mem_hi),       128'(v.hi));
    chk({t, ".lo"},    128'(mem_lo),       128'(v.lo));
    chk({t, ".whilo"}, 128'(mem_whilo),    128'(v.whilo));
    chk({t, ".aluop"}, 128'(mem_aluop),    128'(v.aluop));
    chk({t, ".addr"},  128'(mem_mem_addr), 128'(v.addr));
    chk({t, ".reg2"},  128'(mem_reg2),     128'(v.reg2));
    chk({t, ".valid"}, 128'(mem_valid),    128'(valid));
  endtask

  task automatic exp_acc(input string t,
                         input logic [63:0] h,
                         input logic [1:0] c);
    chk({t, ".hilo"}, 128'(hilo_temp_o), 128'(h));
    chk({t, ".cnt"},  128'(cnt_o),       128'(c));
  endtask

  vec_t zv, va, vb, vc;

  initial begin
    n_chk = 0;
    n_pass = 0;
    zv = '0;
    va = '{5'h1F, 1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 1'b1,
           8'hA3, 32'h1000_0040, 32'hCAFE_F00D};
    vb = '{5'h0A, 1'b1, 32'h1234_5678, 32'h8765_4321, 32'h0F0F_0F0F,
           1'b0, 8'h2C, 32'h8000_0004, 32'hA5A5_5A5A};
    vc = '{5'h15, 1'b0, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555,
           1'b1, 8'hFF, 32'h0000_0FFC, 32'h0000_0001};

    rst = 1'b0;
    stall_ex = 1'b0;
    stall_mem = 1'b0;
    flush = 1'b0;
    w_wd = 6'h3F; w_wreg = 1'b1;
    w_wdata = 64'hFFFF_0000_FFFF_0000;
    w_hi = 64'h0123_4567_89AB_CDEF;
    w_lo = 64'hFEDC_BA98_7654_3210;
    w_whilo = 1'b1; w_aluop = 8'h5A;
    w_addr = 64'h0000_0001_0000_0008;
    w_reg2 = 64'h8000_0000_0000_0001;
    w_hilo_i = {4{$urandom}};
    w_cnt_i = 2'd2;

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(rand_vec());
      hilo_temp_i = {$urandom, $urandom};
      cnt_i = 2'($urandom);
      tick();
      exp_mem("rst", zv, 1'b0);
      exp_acc("rst", 64'h0, 2'd0);
    end
    chk("rst.w64.wdata", 128'(wo_wdata), 128'h0);
    chk("rst.w64.valid", 128'(wo_valid), 128'h0);

    // normal flow
    #2 rst = 1'b1;
    drive(va);
    hilo_temp_i = 64'h1234_5678_9ABC_DEF0;
    cnt_i = 2'd3;
    tick();
    exp_mem("norm", va, 1'b1);
    exp_acc("norm", 64'h0, 2'd0);

    // MADD bubble then capture
    stall_ex = 1'b1;
    drive(vc);
    hilo_temp_i = 64'h0000_0001_0000_0002;
    cnt_i = 2'd1;
    tick();
    exp_mem("bub", zv, 1'b0);
    exp_acc("bub", 64'h0000_0001_0000_0002, 2'd1);
    stall_ex = 1'b0;
    drive(vb);
    hilo_temp_i = 64'hFFFF_FFFF_FFFF_FFFF;
    cnt_i = 2'd2;
    tick();
    exp_mem("bub2cap", vb, 1'b1);
    exp_acc("bub2cap", 64'h0, 2'd0);

    // full hold of a captured instruction
    stall_ex = 1'b1;
    stall_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(rand_vec());
      hilo_temp_i = {$urandom, $urandom};
      cnt_i = 2'($urandom);
      tick();
      exp_mem("hold", vb, 1'b1);
      exp_acc("hold", 64'h0, 2'd0);
    end

    // full hold of a pending accumulation
    stall_mem = 1'b0;
    hilo_temp_i = 64'hA5A5_0000_5A5A_FFFF;
    cnt_i = 2'd2;
    tick();
    exp_acc("bub.b", 64'hA5A5_0000_5A5A_FFFF, 2'd2);
    stall_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(rand_vec());
      hilo_temp_i = {$urandom, $urandom};
      cnt_i = 2'($urandom);
      tick();
      exp_mem("holdacc", zv, 1'b0);
      exp_acc("holdacc", 64'hA5A5_0000_5A5A_FFFF, 2'd2);
    end

    // flush beats bubble
    stall_mem = 1'b0;
    flush = 1'b1;
    drive(va);
    hilo_temp_i = 64'h0000_0001_0000_0002;
    cnt_i = 2'd1;
    tick();
    exp_mem("flbub", zv, 1'b0);
    exp_acc("flbub", 64'h0, 2'd0);

    // flush beats advance
    flush = 1'b0;
    stall_ex = 1'b0;
    drive(vc);
    tick();
    exp_mem("precap", vc, 1'b1);
    flush = 1'b1;
    drive(va);
    tick();
    exp_mem("fladv", zv, 1'b0);
    exp_acc("fladv", 64'h0, 2'd0);

    // stays empty under full stall after flush
    flush = 1'b0;
    stall_ex = 1'b1;
    stall_mem = 1'b1;
    tick();
    exp_mem("flhold", zv, 1'b0);
    exp_acc("flhold", 64'h0, 2'd0);

    // asynchronous reset mid-cycle
    stall_ex = 1'b0;
    stall_mem = 1'b0;
    drive(vb);
    tick();
    exp_mem("prerst", vb, 1'b1);
    #2 rst = 1'b0;
    #1;
    exp_mem("arst", zv, 1'b0);
    drive(va);
    tick();
    exp_mem("arst.edge", zv, 1'b0);

    // release during a stall: first edge inserts a bubble
    #2 rst = 1'b1;
    stall_ex = 1'b1;
    drive(vc);
    hilo_temp_i = 64'h0F0F_0F0F_F0F0_F0F0;
    cnt_i = 2'd3;
    tick();
    exp_mem("relbub", zv, 1'b0);
    exp_acc("relbub", 64'h0F0F_0F0F_F0F0_F0F0, 2'd3);

    // 64-bit instance carries wide data intact
    stall_ex = 1'b0;
    tick();
    chk("w64.wd",    128'(wo_wd),    128'h3F);
    chk("w64.wreg",  128'(wo_wreg),  128'h1);
    chk("w64.wdata", 128'(wo_wdata), 128'hFFFF_0000_FFFF_0000);
    chk("w64.hi",    128'(wo_hi),    128'h0123_4567_89AB_CDEF);
    chk("w64.lo",    128'(wo_lo),    128'hFEDC_BA98_7654_3210);
    chk("w64.addr",  128'(wo_addr),  128'h0000_0001_0000_0008);
    chk("w64.reg2",  128'(wo_reg2),  128'h8000_0000_0000_0001);
    chk("w64.valid", 128'(wo_valid), 128'h1);
    chk("w64.hilo",  wo_hilo,        128'h0);
    chk("w64.cnt",   128'(wo_cnt),   128'h0);
    stall_ex = 1'b1;
    w_hilo_i = 128'hFFFF_0000_1111_2222_3333_4444_5555_6666;
    tick();
    chk("w64.bub.hilo", wo_hilo,
        128'hFFFF_0000_1111_2222_3333_4444_5555_6666);
    chk("w64.bub.cnt", 128'(wo_cnt), 128'h2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
